// File: rtl/tcp_vlg_pkg.sv
// Shared types and default thresholds for the TCP rx delayed-Ack generator.
// TCP_VLG_RX_ACK_GEN_QUICKACK_EN widens the reason field to carry ACK_QUICK.
package tcp_vlg_pkg;

`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
  localparam int unsigned ACK_REASON_W = 4;
`else
  localparam int unsigned ACK_REASON_W = 3;
`endif

  typedef enum logic [ACK_REASON_W-1:0] {
    ACK_NONE,
    ACK_TMO,
    ACK_PKTS,
    ACK_BYTES,
    ACK_OOO,
    ACK_SACK,
    ACK_FIN,
    ACK_WIN
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
    , ACK_QUICK
`endif
  } ack_reason_t;

`ifndef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
  // Nine reasons do not fit three bits; quick-ack aliases the packet-count code.
  localparam ack_reason_t ACK_QUICK = ACK_PKTS;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StPend,
    StReq
  } ack_gen_state_t;

  localparam int unsigned DEF_TIMEOUT           = 20;
  localparam int unsigned DEF_FORCE_ACK_PACKETS = 5;
  localparam int unsigned DEF_FORCE_ACK_BYTES   = 2920;
  localparam int unsigned DEF_QUICKACK_SEGS     = 8;

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? 8'hFF : a + 8'd1;
  endfunction

  function automatic logic [16:0] sat_add17(input logic [16:0] a, input logic [15:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[17] ? 17'h1FFFF : s[16:0];
  endfunction

endpackage

// File: rtl/tcp_vlg_ack_trig.sv
// Priority encoder of delayed-Ack triggers into an ack_reason_t.
// The quick-ack input exists only with TCP_VLG_RX_ACK_GEN_QUICKACK_EN.
module tcp_vlg_ack_trig
  import tcp_vlg_pkg::*;
(
  input  logic        i_fin,
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
  input  logic        i_quick,
`endif
  input  logic        i_ooo,
  input  logic        i_sack,
  input  logic        i_pkts,
  input  logic        i_bytes,
  input  logic        i_win,
  input  logic        i_tmo,
  output ack_reason_t o_reason,
  output logic        o_hit
);

  always_comb begin
    o_reason = ACK_NONE;
    if (i_fin)        o_reason = ACK_FIN;
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
    else if (i_quick) o_reason = ACK_QUICK;
`endif
    else if (i_ooo)   o_reason = ACK_OOO;
    else if (i_sack)  o_reason = ACK_SACK;
    else if (i_pkts)  o_reason = ACK_PKTS;
    else if (i_bytes) o_reason = ACK_BYTES;
    else if (i_win)   o_reason = ACK_WIN;
    else if (i_tmo)   o_reason = ACK_TMO;
  end

  assign o_hit = (o_reason != ACK_NONE);

endmodule

// File: rtl/tcp_vlg_rx_ack_gen.sv
// Delayed-Ack generator: decides when a pure Ack is requested and latches its number/reason.
// TCP_VLG_RX_ACK_GEN_QUICKACK_EN enables immediate Acks for the first segments after init.
module tcp_vlg_rx_ack_gen
  import tcp_vlg_pkg::*;
#(
  parameter int unsigned TIMEOUT           = DEF_TIMEOUT,
  parameter int unsigned FORCE_ACK_PACKETS = DEF_FORCE_ACK_PACKETS,
  parameter int unsigned FORCE_ACK_BYTES   = DEF_FORCE_ACK_BYTES,
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
  parameter int unsigned QUICKACK_SEGS     = DEF_QUICKACK_SEGS,
`endif
  parameter bit          DUPACK_ON_OOO     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_connected,
  input  logic        i_init,
  input  logic        i_rx_vld,
  input  logic        i_rx_in_order,
  input  logic        i_rx_fin,
  input  logic [15:0] i_rx_len,
  input  logic [31:0] i_loc_ack,
  input  logic        i_sack_upd,
  input  logic        i_win_upd,
  input  logic        i_piggy,
  input  logic        i_sent,
  output logic        o_send,
  output logic [31:0] o_ack_num,
  output ack_reason_t o_reason,
  output logic [7:0]  o_pend_pkts
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  ack_gen_state_t r_state;
  logic [7:0]     r_pkts;
  logic [16:0]    r_bytes;
  logic [TMR_W-1:0] r_timer;
  logic           r_send;
  logic [31:0]    r_ack_num;
  ack_reason_t    r_reason;

  logic        w_seg;
  logic        w_fresh;
  logic [7:0]  w_pkts_base;
  logic [16:0] w_bytes_base;
  logic [7:0]  w_pkts_nxt;
  logic [16:0] w_bytes_nxt;
  logic        w_pkts_hit;
  logic        w_bytes_hit;
  logic        w_tmo;
  logic        w_ooo;
  logic        w_hit;
  ack_reason_t w_reason;

  assign w_seg   = i_rx_vld && (i_rx_len != 16'd0);
  // A completed request starts a new epoch, so the counters restart from zero.
  assign w_fresh = (r_state == StWait) || ((r_state == StReq) && i_sent);

  assign w_pkts_base  = w_fresh ? 8'd0 : r_pkts;
  assign w_bytes_base = w_fresh ? 17'd0 : r_bytes;
  assign w_pkts_nxt   = w_seg ? sat_inc8(w_pkts_base) : w_pkts_base;
  assign w_bytes_nxt  = w_seg ? sat_add17(w_bytes_base, i_rx_len) : w_bytes_base;

  assign w_pkts_hit  = w_seg && (({1'b0, w_pkts_base} + 9'd1) >= 9'(FORCE_ACK_PACKETS));
  assign w_bytes_hit = w_seg && (FORCE_ACK_BYTES != 0) &&
                       (({1'b0, w_bytes_base} + {2'b00, i_rx_len}) >= 18'(FORCE_ACK_BYTES));
  assign w_tmo       = (r_state == StPend) && (r_timer == TMR_W'(TIMEOUT - 1));
  assign w_ooo       = DUPACK_ON_OOO && i_rx_vld && !i_rx_in_order;

`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
  logic [3:0] r_quick;
  logic       w_quick;

  assign w_quick = w_seg && (r_quick != 4'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quick <= 4'd0;
    end else if (!i_connected) begin
      r_quick <= r_quick;
    end else if (i_init) begin
      r_quick <= 4'(QUICKACK_SEGS);
    end else if (w_quick && (r_state != StIdle)) begin
      r_quick <= r_quick - 4'd1;
    end
  end
`endif

  tcp_vlg_ack_trig u_trig (
    .i_fin    (i_rx_vld && i_rx_fin),
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
    .i_quick  (w_quick),
`endif
    .i_ooo    (w_ooo),
    .i_sack   (i_sack_upd),
    .i_pkts   (w_pkts_hit),
    .i_bytes  (w_bytes_hit),
    .i_win    (i_win_upd),
    .i_tmo    (w_tmo),
    .o_reason (w_reason),
    .o_hit    (w_hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pkts    <= 8'd0;
      r_bytes   <= 17'd0;
      r_timer   <= '0;
      r_send    <= 1'b0;
      r_ack_num <= 32'd0;
      r_reason  <= ACK_NONE;
    end else if (!i_connected) begin
      r_state <= StIdle;
      r_pkts  <= 8'd0;
      r_bytes <= 17'd0;
      r_timer <= '0;
      r_send  <= 1'b0;
    end else if (i_init) begin
      r_state <= StWait;
      r_pkts  <= 8'd0;
      r_bytes <= 17'd0;
      r_timer <= '0;
      r_send  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_pkts  <= 8'd0;
          r_bytes <= 17'd0;
          r_timer <= '0;
        end
        StPend: begin
          r_timer <= r_timer + TMR_W'(1);
          if (w_hit) begin
            r_state   <= StReq;
            r_send    <= 1'b1;
            r_ack_num <= i_loc_ack;
            r_reason  <= w_reason;
            r_pkts    <= w_pkts_nxt;
            r_bytes   <= w_bytes_nxt;
          end else if (i_piggy) begin
            r_state <= StWait;
            r_pkts  <= 8'd0;
            r_bytes <= 17'd0;
            r_timer <= '0;
          end else begin
            r_pkts  <= w_pkts_nxt;
            r_bytes <= w_bytes_nxt;
          end
        end
        StWait, StReq: begin
          if ((r_state == StReq) && !i_sent) begin
            // Request outstanding: keep counting and refresh the latched Ack.
            r_pkts  <= w_pkts_nxt;
            r_bytes <= w_bytes_nxt;
            if (w_hit) begin
              r_ack_num <= i_loc_ack;
              r_reason  <= w_reason;
            end
          end else begin
            r_pkts  <= w_pkts_nxt;
            r_bytes <= w_bytes_nxt;
            r_timer <= '0;
            if (w_hit) begin
              r_state   <= StReq;
              r_send    <= 1'b1;
              r_ack_num <= i_loc_ack;
              r_reason  <= w_reason;
            end else if (w_seg) begin
              r_state <= StPend;
              r_send  <= 1'b0;
            end else begin
              r_state <= StWait;
              r_send  <= 1'b0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_send      = r_send;
  assign o_ack_num   = r_ack_num;
  assign o_reason    = r_reason;
  assign o_pend_pkts = r_pkts;

endmodule

// File: tb/tb_tcp_vlg_rx_ack_gen.sv
// Directed bench for tcp_vlg_rx_ack_gen with default parameters.
// The quick-ack sequence runs only when TCP_VLG_RX_ACK_GEN_QUICKACK_EN is defined.
module tb_tcp_vlg_rx_ack_gen;
  import tcp_vlg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        connected = 1'b0;
  logic        init = 1'b0;
  logic        rx_vld = 1'b0;
  logic        rx_in_order = 1'b1;
  logic        rx_fin = 1'b0;
  logic [15:0] rx_len = 16'd0;
  logic [31:0] loc_ack = 32'd0;
  logic        sack_upd = 1'b0;
  logic        win_upd = 1'b0;
  logic        piggy = 1'b0;
  logic        sent = 1'b0;
  logic        send;
  logic [31:0] ack_num;
  ack_reason_t reason;
  logic [7:0]  pend_pkts;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcp_vlg_rx_ack_gen dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_connected  (connected),
    .i_init       (init),
    .i_rx_vld     (rx_vld),
    .i_rx_in_order(rx_in_order),
    .i_rx_fin     (rx_fin),
    .i_rx_len     (rx_len),
    .i_loc_ack    (loc_ack),
    .i_sack_upd   (sack_upd),
    .i_win_upd    (win_upd),
    .i_piggy      (piggy),
    .i_sent       (sent),
    .o_send       (send),
    .o_ack_num    (ack_num),
    .o_reason     (reason),
    .o_pend_pkts  (pend_pkts)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic [15:0] len, input logic in_order, input logic fin);
    rx_vld = 1'b1; rx_len = len; rx_in_order = in_order; rx_fin = fin;
    tick();
    rx_vld = 1'b0; rx_len = 16'd0; rx_in_order = 1'b1; rx_fin = 1'b0;
  endtask

  task automatic do_sent();
    sent = 1'b1;
    tick();
    sent = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_send", {31'd0, send}, 32'd0);
    chk("rst_ack_num", ack_num, 32'd0);
    chk("rst_reason", 32'(reason), 32'(ACK_NONE));
    chk("rst_pend", {24'd0, pend_pkts}, 32'd0);
    rst = 1'b0;
    tick();

    connected = 1'b1; init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_send", {31'd0, send}, 32'd0);

`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
    loc_ack = 32'd500;
    for (int i = 0; i < 8; i++) begin
      seg(16'd100, 1'b1, 1'b0);
      chk("quick_send", {31'd0, send}, 32'd1);
      chk("quick_reason", 32'(reason), 32'(ACK_QUICK));
      do_sent();
    end
    seg(16'd100, 1'b1, 1'b0);
    chk("quick9_send", {31'd0, send}, 32'd0);
    chk("quick9_pend", {24'd0, pend_pkts}, 32'd1);
    piggy = 1'b1; tick(); piggy = 1'b0;
`endif

    // Timeout: three 100-byte segments, request TIMEOUT cycles after the first.
    loc_ack = 32'd1300;
    seg(16'd100, 1'b1, 1'b0);
    chk("tmo_pend1", {24'd0, pend_pkts}, 32'd1);
    seg(16'd100, 1'b1, 1'b0);
    seg(16'd100, 1'b1, 1'b0);
    chk("tmo_pend3", {24'd0, pend_pkts}, 32'd3);
    for (int i = 0; i < 17; i++) tick();
    chk("tmo_early", {31'd0, send}, 32'd0);
    tick();
    chk("tmo_send", {31'd0, send}, 32'd1);
    chk("tmo_reason", 32'(reason), 32'(ACK_TMO));
    chk("tmo_ack_num", ack_num, 32'd1300);
    do_sent();
    chk("tmo_cleared_send", {31'd0, send}, 32'd0);
    chk("tmo_cleared_pend", {24'd0, pend_pkts}, 32'd0);

    // Packet count threshold.
    loc_ack = 32'd2000;
    for (int i = 0; i < 4; i++) seg(16'd10, 1'b1, 1'b0);
    chk("pkts_4_send", {31'd0, send}, 32'd0);
    chk("pkts_4_pend", {24'd0, pend_pkts}, 32'd4);
    seg(16'd10, 1'b1, 1'b0);
    chk("pkts_send", {31'd0, send}, 32'd1);
    chk("pkts_reason", 32'(reason), 32'(ACK_PKTS));
    chk("pkts_pend5", {24'd0, pend_pkts}, 32'd5);
    chk("pkts_ack_num", ack_num, 32'd2000);
    do_sent();
    chk("pkts_cleared", {24'd0, pend_pkts}, 32'd0);

    // Byte threshold: 2 x 1460 = 2920.
    seg(16'd1460, 1'b1, 1'b0);
    chk("bytes_1_send", {31'd0, send}, 32'd0);
    seg(16'd1460, 1'b1, 1'b0);
    chk("bytes_send", {31'd0, send}, 32'd1);
    chk("bytes_reason", 32'(reason), 32'(ACK_BYTES));
    do_sent();

    // Out-of-order while pending.
    seg(16'd100, 1'b1, 1'b0);
    chk("ooo_pre_send", {31'd0, send}, 32'd0);
    seg(16'd100, 1'b0, 1'b0);
    chk("ooo_send", {31'd0, send}, 32'd1);
    chk("ooo_reason", 32'(reason), 32'(ACK_OOO));
    do_sent();

    // FIN outranks a simultaneous SACK change.
    sack_upd = 1'b1;
    seg(16'd0, 1'b1, 1'b1);
    sack_upd = 1'b0;
    chk("fin_send", {31'd0, send}, 32'd1);
    chk("fin_reason", 32'(reason), 32'(ACK_FIN));
    do_sent();

    // Piggyback cancels the pending Ack; no timeout follows.
    seg(16'd100, 1'b1, 1'b0);
    piggy = 1'b1; tick(); piggy = 1'b0;
    chk("piggy_pend", {24'd0, pend_pkts}, 32'd0);
    for (int i = 0; i < 25; i++) tick();
    chk("piggy_no_send", {31'd0, send}, 32'd0);

    // SACK request, then a window update refreshes ack_num while still requesting.
    sack_upd = 1'b1; tick(); sack_upd = 1'b0;
    chk("sack_reason", 32'(reason), 32'(ACK_SACK));
    loc_ack = 32'd5000;
    win_upd = 1'b1; tick(); win_upd = 1'b0;
    chk("req_upd_send", {31'd0, send}, 32'd1);
    chk("req_upd_ack_num", ack_num, 32'd5000);
    chk("req_upd_reason", 32'(reason), 32'(ACK_WIN));

    // Segment in the same cycle as sent opens a fresh epoch.
    sent = 1'b1;
    seg(16'd100, 1'b1, 1'b0);
    sent = 1'b0;
    chk("sent_seg_send", {31'd0, send}, 32'd0);
    chk("sent_seg_pend", {24'd0, pend_pkts}, 32'd1);

    // Connection drop while requesting.
    sack_upd = 1'b1; tick(); sack_upd = 1'b0;
    chk("drop_pre_send", {31'd0, send}, 32'd1);
    connected = 1'b0;
    tick();
    chk("drop_send", {31'd0, send}, 32'd0);
    chk("drop_pend", {24'd0, pend_pkts}, 32'd0);
    connected = 1'b1;
    seg(16'd100, 1'b1, 1'b0);
    chk("idle_no_pend", {24'd0, pend_pkts}, 32'd0);
    chk("idle_no_send", {31'd0, send}, 32'd0);

    init = 1'b1; tick(); init = 1'b0;
`ifdef TCP_VLG_RX_ACK_GEN_QUICKACK_EN
    for (int i = 0; i < 8; i++) begin
      seg(16'd1, 1'b1, 1'b0);
      do_sent();
    end
`endif
    // Zero-length in-order segment creates no pending state.
    seg(16'd0, 1'b1, 1'b0);
    chk("zero_len_pend", {24'd0, pend_pkts}, 32'd0);
    chk("zero_len_send", {31'd0, send}, 32'd0);
    seg(16'd100, 1'b1, 1'b0);
    chk("after_init_pend", {24'd0, pend_pkts}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
